// File: rtl/dm_ctrl.sv
// Data-memory controller for the MEM stage: lane-masked stores, extended combinational loads,
// sticky misalignment capture. Optional MMIO window (LED, cycle counter) under DM_MMIO_EN.
module dm_ctrl #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_w_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  dm_type_i,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic [31:0] misalign_addr_o,
   output logic [15:0] led_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] widx;
   logic          is_half, is_byte, is_word, is_signed;
   logic          bad_align, bad_access, in_win;
   logic [3:0]    be;
   logic [31:0]   wlane, ram_word, ram_shift, ram_ext, mmio_rd;
   logic          ram_we;
   logic          misalign_q, misalign_d;
   logic [31:0]   misalign_addr_q, misalign_addr_d;

   assign widx      = addr_i[AW+1:2];
   assign is_half   = (dm_type_i == 3'b001) || (dm_type_i == 3'b010);
   assign is_byte   = (dm_type_i == 3'b011) || (dm_type_i == 3'b100);
   assign is_word   = !is_half && !is_byte;
   assign is_signed = (dm_type_i == 3'b001) || (dm_type_i == 3'b011);

   assign bad_align  = (is_word && (addr_i[1:0] != 2'b00)) || (is_half && addr_i[0]);
   // The MMIO registers only accept whole-word accesses; anything else is reported like misalignment.
   assign bad_access = bad_align || (in_win && !is_word);

   always_comb begin
      be    = 4'b0000;
      wlane = wdata_i;
      if (is_byte) begin
         be    = 4'b0001 << addr_i[1:0];
         wlane = {4{wdata_i[7:0]}};
      end else if (is_half) begin
         be    = addr_i[1] ? 4'b1100 : 4'b0011;
         wlane = {2{wdata_i[15:0]}};
      end else begin
         be    = 4'b1111;
      end
   end

   assign ram_we = mem_w_i && !reset && !bad_access && !in_win;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we && be[i]) mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
   end

   assign ram_word  = mem_q[widx];
   assign ram_shift = ram_word >> {addr_i[1:0], 3'b000};

   always_comb begin
      ram_ext = ram_word;
      if (is_byte) begin
         ram_ext = {{24{is_signed & ram_shift[7]}}, ram_shift[7:0]};
      end else if (is_half) begin
         ram_ext = addr_i[1] ? {{16{is_signed & ram_word[31]}}, ram_word[31:16]}
                             : {{16{is_signed & ram_word[15]}}, ram_word[15:0]};
      end
   end

   always_comb begin
      rdata_o = ram_ext;
      if (bad_access)  rdata_o = 32'h0;
      else if (in_win) rdata_o = mmio_rd;
   end

   // Only the first offending address is kept; the flag stays set until reset.
   always_comb begin
      misalign_d      = misalign_q;
      misalign_addr_d = misalign_addr_q;
      if (bad_access) begin
         misalign_d = 1'b1;
         if (!misalign_q) misalign_addr_d = addr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q      <= 1'b0;
         misalign_addr_q <= 32'h0;
      end else begin
         misalign_q      <= misalign_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   assign misalign_o      = misalign_q;
   assign misalign_addr_o = misalign_addr_q;

`ifdef DM_MMIO_EN
   logic [15:0] led_q, led_d;
   logic [31:0] cnt_q, cnt_d;

   assign in_win  = (addr_i[31:3] == MMIO_BASE[31:3]);
   assign mmio_rd = addr_i[2] ? cnt_q : {16'h0, led_q};

   always_comb begin
      led_d = led_q;
      cnt_d = cnt_q + 32'd1;
      if (mem_w_i && in_win && !bad_access && !addr_i[2]) led_d = wdata_i[15:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= 16'h0;
         cnt_q <= 32'h0;
      end else begin
         led_q <= led_d;
         cnt_q <= cnt_d;
      end
   end

   assign led_o = led_q;
`else
   logic unused_bits;

   assign in_win      = 1'b0;
   assign mmio_rd     = 32'h0;
   assign led_o       = 16'h0;
   assign unused_bits = ^{addr_i[31:AW+2], MMIO_BASE};
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed self-checking bench for dm_ctrl; MMIO checks follow DM_MMIO_EN.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [15:0] led;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] cnt_a, cnt_b;

  localparam logic [2:0] T_W = 3'b000, T_H = 3'b001, T_HU = 3'b010, T_B = 3'b011, T_BU = 3'b100;

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .mem_w_i         (mem_w),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .dm_type_i       (dm_type),
    .rdata_o         (rdata),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr),
    .led_o           (led)
  );

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    mem_w   = w;
    addr    = a;
    wdata   = d;
    dm_type = t;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    drive(1'b1, a, d, t);
    tick();
    drive(1'b0, 32'h0, 32'h0, T_W);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, T_W);
    tick();
    tick();
    chk("reset_misalign", {31'h0, misalign}, 32'h0);
    chk("reset_misalign_addr", misalign_addr, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    reset = 1'b0;

    // word store then every load flavour
    store(32'h10, 32'h8765_4321, T_W);
    drive(1'b0, 32'h10, 32'h0, T_W);  chk("ld_word_10", rdata, 32'h8765_4321);
    drive(1'b0, 32'h13, 32'h0, T_B);  chk("ld_byte_13", rdata, 32'hFFFF_FF87);
    drive(1'b0, 32'h13, 32'h0, T_BU); chk("ld_byteu_13", rdata, 32'h0000_0087);
    drive(1'b0, 32'h12, 32'h0, T_H);  chk("ld_half_12", rdata, 32'hFFFF_8765);
    drive(1'b0, 32'h10, 32'h0, T_HU); chk("ld_halfu_10", rdata, 32'h0000_4321);
    drive(1'b0, 32'h11, 32'h0, T_BU); chk("ld_byteu_11", rdata, 32'h0000_0043);
    drive(1'b0, 32'h10, 32'h0, 3'b110); chk("ld_type110_word", rdata, 32'h8765_4321);

    // store and load in the same cycle shows old contents
    drive(1'b1, 32'h10, 32'h1111_1111, T_W);
    chk("same_cycle_old", rdata, 32'h8765_4321);
    tick();
    drive(1'b0, 32'h10, 32'h0, T_W);
    chk("after_edge_new", rdata, 32'h1111_1111);

    // sub-word stores with lane masking
    store(32'h20, 32'h0, T_W);
    store(32'h21, 32'hFFFF_FFAB, T_B);
    drive(1'b0, 32'h20, 32'h0, T_W); chk("byte_store_21", rdata, 32'h0000_AB00);
    store(32'h22, 32'h1234_CDEF, T_H);
    drive(1'b0, 32'h20, 32'h0, T_W); chk("half_store_22", rdata, 32'hCDEF_AB00);
    store(32'h20, 32'h5A, T_BU);
    drive(1'b0, 32'h20, 32'h0, T_W); chk("byteu_store_20", rdata, 32'hCDEF_AB5A);

    // NOP bubbles never flag
    tick();
    tick();
    chk("nop_no_misalign", {31'h0, misalign}, 32'h0);

    // misaligned store
    store(32'h30, 32'h5555_AAAA, T_W);
    drive(1'b1, 32'h31, 32'hDEAD_BEEF, T_W);
    chk("misal_rdata_zero", rdata, 32'h0);
    chk("misal_flag_before_edge", {31'h0, misalign}, 32'h0);
    tick();
    drive(1'b0, 32'h30, 32'h0, T_W);
    chk("misal_flag_set", {31'h0, misalign}, 32'h1);
    chk("misal_addr_31", misalign_addr, 32'h31);
    chk("misal_no_ram_change", rdata, 32'h5555_AAAA);
    drive(1'b0, 32'h45, 32'h0, T_HU);
    chk("misal_half_rdata_zero", rdata, 32'h0);
    tick();
    chk("misal_addr_sticky", misalign_addr, 32'h31);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, T_W);
    tick();
    reset = 1'b0;
    chk("misal_cleared", {31'h0, misalign}, 32'h0);
    chk("misal_addr_cleared", misalign_addr, 32'h0);

    // aliasing above the RAM depth
    store(32'h10 + 32'd4096, 32'h0BAD_F00D, T_W);
    drive(1'b0, 32'h10, 32'h0, T_W); chk("alias_10", rdata, 32'h0BAD_F00D);

    // MMIO window
    store(32'h0, 32'hA5A5_A5A5, T_W);
    store(32'hFFFF_0000, 32'h1234_5678, T_W);
    drive(1'b0, 32'h0, 32'h0, T_W);
`ifdef DM_MMIO_EN
    chk("mmio_led", {16'h0, led}, 32'h0000_5678);
    chk("mmio_ram0_unchanged", rdata, 32'hA5A5_A5A5);
    drive(1'b0, 32'hFFFF_0000, 32'h0, T_W);
    chk("mmio_led_read", rdata, 32'h0000_5678);
    drive(1'b0, 32'hFFFF_0004, 32'h0, T_W);
    cnt_a = rdata;
    repeat (5) tick();
    cnt_b = rdata;
    chk("mmio_cnt_delta", cnt_b - cnt_a, 32'd5);
    store(32'hFFFF_0000, 32'h99, T_B);
    chk("mmio_byte_misal", {31'h0, misalign}, 32'h1);
    chk("mmio_byte_misal_addr", misalign_addr, 32'hFFFF_0000);
    chk("mmio_byte_led_kept", {16'h0, led}, 32'h0000_5678);
`else
    chk("nommio_led_zero", {16'h0, led}, 32'h0);
    chk("nommio_alias_ram0", rdata, 32'h1234_5678);
    store(32'hFFFF_0000, 32'h99, T_B);
    chk("nommio_byte_no_misal", {31'h0, misalign}, 32'h0);
    drive(1'b0, 32'h0, 32'h0, T_W);
    chk("nommio_byte_written", rdata, 32'h1234_5699);
`endif

    // reset suppresses stores
    store(32'h40, 32'h7777_7777, T_W);
    reset = 1'b1;
    drive(1'b1, 32'h40, 32'h9999_9999, T_W);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h40, 32'h0, T_W);
    chk("reset_store_suppressed", rdata, 32'h7777_7777);
    chk("reset_led_cleared", {16'h0, led}, 32'h0);
    chk("reset_misal_cleared", {31'h0, misalign}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
